misr_result_compactor: RTL and testbench
========================================

// Module: misr_result_compactor
// PURPOSE
//  Downstream signature stage for the adder_subtractor_net gate-level netlist.
//  - Compacts the 9-bit result[0:8] bus, one vector per accepted cycle, into a
//    multiple-input signature register (MISR).
//  - A session FSM counts N_PATTERNS vectors, then compares the final signature
//    against a golden value and reports pass/fail.
//  - Used by the fault-dictionary flow to sign each faulty netlist instance.
// PARAMETERS
//  DIN_WIDTH   9        width of compacted input bus (result[0:DIN_WIDTH-1])
//  SIG_WIDTH   16       signature width, >= DIN_WIDTH
//  POLY        16'h1021 feedback taps (x^16+x^12+x^5+1); bit k taps sig[k]
//  SEED        16'h0000 signature value loaded on start
//  N_PATTERNS  256      vectors per session, >= 1
//  CNT_WIDTH   9        pattern counter width, holds N_PATTERNS
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  start     in   1          one-cycle pulse that opens a session (IDLE/DONE only)
//  din       in   [0:8]      result bus from adder_subtractor_net; din[0] is the MSB
//  din_valid in   1          din holds a vector to compact this cycle
//  golden    in   SIG_WIDTH  expected signature, sampled at session end
//  busy      out  1          high in RUN
//  done      out  1          high in DONE
//  pass      out  1          final signature == golden; valid only while done=1
//  signature out  SIG_WIDTH  current MISR contents
//  pat_count out  CNT_WIDTH  vectors accepted in the current session
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; signature=SEED; pat_count=0; busy=done=pass=0.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE, start=1: on the next edge load signature=SEED, pat_count=0, go to RUN.
//   - RUN: each edge with din_valid=1 compacts din and increments pat_count.
//     din_valid=0 holds signature and pat_count (stall).
//   - RUN, accepted vector makes pat_count==N_PATTERNS: on that same edge go to
//     DONE and register pass = (next signature == golden).
//   - DONE: signature, pat_count and pass hold.
//     start=1 reloads SEED and re-enters RUN, as from IDLE.
//   - start in RUN is ignored. din_valid in IDLE or DONE is ignored.
//  MISR update, per accepted vector:
//   - fb = signature[SIG_WIDTH-1]
//   - next = {signature[SIG_WIDTH-2:0],1'b0} ^ (fb ? POLY : 0) ^ dmap
//   - dmap[DIN_WIDTH-1-i] = din[i]; upper bits of dmap are 0.
//     So din[8] (LSB) lands in sig[0] and din[0] lands in sig[8].
//  Timing:
//   - Latency: done/pass become visible the cycle after the edge that accepts
//     the last vector. signature reflects each accepted vector one cycle later.
//   - pass is registered and does not track golden after DONE is entered.
//  Boundaries:
//   - N_PATTERNS=1: a single accepted vector ends the session.
//   - pat_count never exceeds N_PATTERNS and never wraps.
//   - Reset asserted mid-session: immediate return to reset values; no partial
//     result is retained.
//   - All outputs are driven from registers, with no combinational paths from inputs.
// TESTING
//  1. Reset value: rst_n=0 then 1, SEED=0 -> signature=0x0000, busy=done=pass=0,
//     state IDLE.
//  2. Basic session (N_PATTERNS=2, SEED=0, golden=0x0002): start, then
//     din=9'h001, then din=9'h000 -> signature 0x0001 then 0x0002;
//     done=1, pass=1 one cycle after the 2nd vector.
//  3. Feedback path (N_PATTERNS=1, SEED=0x8000, golden=0x0000): din=9'h000 ->
//     signature=0x1021, pass=0, done=1.
//  4. Bit mapping (N_PATTERNS=1, SEED=0): din=9'h100 (din[0]=1) -> signature=0x0100.
//  5. Stalls and ignored start (N_PATTERNS=2):
//     - din_valid low 3 cycles between vectors -> signature and pat_count hold.
//     - start pulse in RUN -> no reload; pat_count still reaches 2.
//  6. Reset mid-session: rst_n=0 after 1 accepted vector -> signature=SEED,
//     pat_count=0, IDLE; a fresh session then passes.

Source files
------------

// File: rtl/misr_result_compactor_if.sv
// Handshake/bus bundle between the adder_subtractor_net result stream and the
// MISR signature compactor: session control, compacted data and signature status.
interface misr_result_compactor_if #(
  parameter int DIN_WIDTH = 9,
  parameter int SIG_WIDTH = 16,
  parameter int CNT_WIDTH = 9
);
  logic                 start;
  logic [0:DIN_WIDTH-1] din;
  logic                 din_valid;
  logic [SIG_WIDTH-1:0] golden;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [SIG_WIDTH-1:0] signature;
  logic [CNT_WIDTH-1:0] pat_count;

  // Stimulus side: drives the session and the result bus, observes status.
  modport master (
    output start, din, din_valid, golden,
    input  busy, done, pass, signature, pat_count
  );

  // Compactor side.
  modport slave (
    input  start, din, din_valid, golden,
    output busy, done, pass, signature, pat_count
  );
endinterface

// File: rtl/misr_result_compactor.sv
// Multiple-input signature register for the 9-bit result bus: compacts
// N_PATTERNS accepted vectors per session and compares the result against a golden value.
module misr_result_compactor #(
  parameter int                   DIN_WIDTH  = 9,
  parameter int                   SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SEED       = 16'h0000,
  parameter int                   N_PATTERNS = 256,
  parameter int                   CNT_WIDTH  = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  misr_result_compactor_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N_PATTERNS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // din[0] is the bus MSB, so the bit-reversing index keeps numeric order:
  // din[DIN_WIDTH-1] lands in sig[0], din[0] in sig[DIN_WIDTH-1].
  function automatic logic [SIG_WIDTH-1:0] misr_next(
    input logic [SIG_WIDTH-1:0] sig,
    input logic [0:DIN_WIDTH-1] d
  );
    logic [SIG_WIDTH-1:0] dmap;
    dmap = '0;
    for (int i = 0; i < DIN_WIDTH; i++) begin
      dmap[DIN_WIDTH-1-i] = d[i];
    end
    misr_next = {sig[SIG_WIDTH-2:0], 1'b0}
              ^ (sig[SIG_WIDTH-1] ? POLY : {SIG_WIDTH{1'b0}})
              ^ dmap;
  endfunction

  state_e               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SIG_WIDTH-1:0] sig_nxt_s;

  // Next-state and datapath decode for the session FSM.
  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    sig_nxt_s = misr_next(sig_q, bus.din);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          sig_d   = SEED;
          cnt_d   = {CNT_WIDTH{1'b0}};
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (bus.din_valid) begin
          sig_d = sig_nxt_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            pass_d  = (sig_nxt_s == bus.golden);
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sig_d   = SEED;
        cnt_d   = {CNT_WIDTH{1'b0}};
        pass_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, signature, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= {CNT_WIDTH{1'b0}};
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.pat_count = cnt_q;

endmodule

// File: tb/tb_misr_result_compactor.sv
// Directed bench for misr_result_compactor: three instances cover the two-vector
// session, the single-vector feedback case and the single-vector bit mapping.
module tb_misr_result_compactor;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   bad_cnt;

  misr_result_compactor_if #(.DIN_WIDTH(9), .SIG_WIDTH(16), .CNT_WIDTH(9)) b2 ();
  misr_result_compactor_if #(.DIN_WIDTH(9), .SIG_WIDTH(16), .CNT_WIDTH(9)) b1 ();
  misr_result_compactor_if #(.DIN_WIDTH(9), .SIG_WIDTH(16), .CNT_WIDTH(9)) bf ();

  misr_result_compactor #(.DIN_WIDTH(9), .SIG_WIDTH(16), .POLY(16'h1021),
    .SEED(16'h0000), .N_PATTERNS(2), .CNT_WIDTH(9))
    u_n2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  misr_result_compactor #(.DIN_WIDTH(9), .SIG_WIDTH(16), .POLY(16'h1021),
    .SEED(16'h0000), .N_PATTERNS(1), .CNT_WIDTH(9))
    u_n1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  misr_result_compactor #(.DIN_WIDTH(9), .SIG_WIDTH(16), .POLY(16'h1021),
    .SEED(16'h8000), .N_PATTERNS(1), .CNT_WIDTH(9))
    u_fb (.clk(clk), .rst_n(rst_n), .bus(bf.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a session on the two-pattern instance.
  task automatic start_n2(input logic [15:0] gold);
    b2.golden = gold;
    b2.start  = 1'b1;
    tick();
    b2.start  = 1'b0;
  endtask

  task automatic push_n2(input logic [8:0] v);
    b2.din       = v;
    b2.din_valid = 1'b1;
    tick();
    b2.din_valid = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    b2.start = 1'b0; b2.din = 9'h000; b2.din_valid = 1'b0; b2.golden = 16'h0000;
    b1.start = 1'b0; b1.din = 9'h000; b1.din_valid = 1'b0; b1.golden = 16'h0000;
    bf.start = 1'b0; bf.din = 9'h000; bf.din_valid = 1'b0; bf.golden = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1. reset values
    check_eq("rst_sig",  32'(b2.signature), 32'h0000);
    check_eq("rst_cnt",  32'(b2.pat_count), 32'd0);
    check_eq("rst_busy", 32'(b2.busy),      32'd0);
    check_eq("rst_done", 32'(b2.done),      32'd0);
    check_eq("rst_pass", 32'(b2.pass),      32'd0);
    check_eq("rst_seed_fb", 32'(bf.signature), 32'h8000);

    // 2. basic two-vector session
    start_n2(16'h0002);
    check_eq("s2_busy", 32'(b2.busy), 32'd1);
    check_eq("s2_sig0", 32'(b2.signature), 32'h0000);
    push_n2(9'h001);
    check_eq("s2_sig1", 32'(b2.signature), 32'h0001);
    check_eq("s2_cnt1", 32'(b2.pat_count), 32'd1);
    check_eq("s2_done1", 32'(b2.done), 32'd0);
    push_n2(9'h000);
    check_eq("s2_sig2", 32'(b2.signature), 32'h0002);
    check_eq("s2_cnt2", 32'(b2.pat_count), 32'd2);
    check_eq("s2_done", 32'(b2.done), 32'd1);
    check_eq("s2_pass", 32'(b2.pass), 32'd1);
    check_eq("s2_busy_off", 32'(b2.busy), 32'd0);
    // din_valid and golden changes in DONE are ignored
    b2.golden = 16'h1234;
    push_n2(9'h1FF);
    check_eq("done_sig_hold",  32'(b2.signature), 32'h0002);
    check_eq("done_cnt_hold",  32'(b2.pat_count), 32'd2);
    check_eq("done_pass_hold", 32'(b2.pass), 32'd1);

    // 3. feedback path
    bf.golden = 16'h0000;
    bf.start = 1'b1; tick(); bf.start = 1'b0;
    check_eq("fb_seed", 32'(bf.signature), 32'h8000);
    bf.din = 9'h000; bf.din_valid = 1'b1; tick(); bf.din_valid = 1'b0;
    check_eq("fb_sig",  32'(bf.signature), 32'h1021);
    check_eq("fb_done", 32'(bf.done), 32'd1);
    check_eq("fb_pass", 32'(bf.pass), 32'd0);

    // 4. bit mapping, N_PATTERNS=1
    b1.golden = 16'h0100;
    b1.start = 1'b1; tick(); b1.start = 1'b0;
    b1.din = 9'h100; b1.din_valid = 1'b1; tick(); b1.din_valid = 1'b0;
    check_eq("map_sig",  32'(b1.signature), 32'h0100);
    check_eq("map_cnt",  32'(b1.pat_count), 32'd1);
    check_eq("map_pass", 32'(b1.pass), 32'd1);

    // 5. restart from DONE, stalls, start ignored in RUN
    start_n2(16'h0001);
    check_eq("rs_busy", 32'(b2.busy), 32'd1);
    check_eq("rs_done", 32'(b2.done), 32'd0);
    check_eq("rs_pass", 32'(b2.pass), 32'd0);
    check_eq("rs_cnt",  32'(b2.pat_count), 32'd0);
    push_n2(9'h001);
    for (int i = 0; i < 3; i++) tick();
    check_eq("stall_sig", 32'(b2.signature), 32'h0001);
    check_eq("stall_cnt", 32'(b2.pat_count), 32'd1);
    b2.start = 1'b1; tick(); b2.start = 1'b0;
    check_eq("run_start_sig", 32'(b2.signature), 32'h0001);
    check_eq("run_start_cnt", 32'(b2.pat_count), 32'd1);
    push_n2(9'h003);
    check_eq("s5_sig",  32'(b2.signature), 32'h0001);
    check_eq("s5_cnt",  32'(b2.pat_count), 32'd2);
    check_eq("s5_done", 32'(b2.done), 32'd1);
    check_eq("s5_pass", 32'(b2.pass), 32'd1);

    // 6. reset mid-session, then a fresh session
    start_n2(16'h0002);
    push_n2(9'h0AA);
    check_eq("mid_sig", 32'(b2.signature), 32'h00AA);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_sig",  32'(b2.signature), 32'h0000);
    check_eq("mr_cnt",  32'(b2.pat_count), 32'd0);
    check_eq("mr_busy", 32'(b2.busy), 32'd0);
    check_eq("mr_done", 32'(b2.done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_n2(16'h0002);
    push_n2(9'h001);
    push_n2(9'h000);
    check_eq("fresh_sig",  32'(b2.signature), 32'h0002);
    check_eq("fresh_done", 32'(b2.done), 32'd1);
    check_eq("fresh_pass", 32'(b2.pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
